uart_rx_deser: RTL and testbench

//  Serial receiver; consumes the Tx line produced by Dataflow_Tx (idle-high, 1 start bit =0,
//  n data bits LSB first, 1 stop bit =1). Samples mid-bit, deserialises, presents a parallel

---
 rtl/uart_rx_deser_if.sv | 14 +
 rtl/uart_rx_deser.sv | 125 ++++++++++++
 tb/tb_uart_rx_deser.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deser_if.sv
// Serial receive link bundle: the line into the deserialiser and the word/status it reports back.
// master = line driver / word consumer, slave = uart_rx_deser.
interface uart_rx_deser_if #(
    parameter int n = 8
);
    logic         rx;
    logic [n-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         busy;

    modport master (output rx, input data, input valid, input frame_err, input busy);
    modport slave  (input rx, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx_deser.sv
// Mid-bit sampling UART receiver (start 0, n data bits LSB first, stop 1) with framing-error detection.
// Define RX_SYNC_EN to pass rx through a 2-flop synchroniser (adds 2 cycles of latency).
module uart_rx_deser #(
    parameter int n            = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input logic            clk,
    input logic            rst,
    uart_rx_deser_if.slave bus
);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(n + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((H > 0) ? (H - 1) : 0);
    localparam logic [BW-1:0] BIT_LAST = BW'(n - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bitcnt;
    logic [n-1:0]  shift;
    logic [n-1:0]  shift_nxt;
    logic          rx_s;
    logic          tick;

`ifdef RX_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], bus.rx};
    end

    assign rx_s = sync[1];
`else
    assign rx_s = bus.rx;
`endif

    assign tick = (cnt == CNT_LAST);

    always_comb begin
        shift_nxt        = shift >> 1;
        shift_nxt[n-1]   = rx_s;
    end

    // cnt counts edges since the previous sample point, so a sample falls every CLKS_PER_BIT edges
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bitcnt        <= '0;
            shift         <= '0;
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt      <= '0;
                        bitcnt   <= '0;
                        bus.busy <= 1'b1;
                        state    <= (H == 0) ? DATA : START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt    <= '0;
                        shift  <= shift_nxt;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == BIT_LAST) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt <= '0;
                        if (rx_s) begin
                            bus.data  <= shift;
                            bus.valid <= 1'b1;
                            bus.busy  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            bus.frame_err <= 1'b1;
                            state         <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    // a line stuck low must not be mistaken for a new start bit
                    if (rx_s) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: one instance at 1 clk/bit, one at 4 clk/bit, sharing clk and rst.
// Timing expectations shift by 2 cycles when RX_SYNC_EN is defined.
module tb_uart_rx_deser;
`ifdef RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_deser_if #(.n(8)) bus1 ();
    uart_rx_deser_if #(.n(8)) bus4 ();

    uart_rx_deser #(.n(8), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    uart_rx_deser #(.n(8), .CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         v1Cyc[$];
    logic [7:0] v1Dat[$];
    int         e1Cyc[$];
    int         v4Cyc[$];
    logic [7:0] v4Dat[$];
    int         e4Cyc[$];
    int         bothCount = 0;

    // record every output pulse with the cycle it was seen in
    always @(negedge clk) begin
        if (bus1.valid) begin
            v1Cyc.push_back(cyc);
            v1Dat.push_back(bus1.data);
        end
        if (bus1.frame_err) e1Cyc.push_back(cyc);
        if (bus4.valid) begin
            v4Cyc.push_back(cyc);
            v4Dat.push_back(bus4.data);
        end
        if (bus4.frame_err) e4Cyc.push_back(cyc);
        if ((bus1.valid && bus1.frame_err) || (bus4.valid && bus4.frame_err)) bothCount++;
    end

    int assertCount = 0;
    int failCount   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic setRx(input int which, input logic v);
        if (which == 4) bus4.rx = v;
        else            bus1.rx = v;
    endtask

    // which doubles as clocks-per-bit of the targeted instance
    task automatic holdBit(input int which, input logic v);
        setRx(which, v);
        repeat (which) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] d, input logic stopBit, output int startCyc);
        startCyc = cyc;
        holdBit(which, 1'b0);
        for (int i = 0; i < 8; i++) holdBit(which, d[i]);
        holdBit(which, stopBit);
    endtask

    task automatic clearQueues();
        v1Cyc.delete(); v1Dat.delete(); e1Cyc.delete();
        v4Cyc.delete(); v4Dat.delete(); e4Cyc.delete();
    endtask

    int s;
    int s2;

    initial begin
        rst     = 1'b1;
        bus1.rx = 1'b1;
        bus4.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // idle line after reset
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t1_valid_cnt", v1Cyc.size() + v4Cyc.size(), 0);
        checkOutput("t1_err_cnt", e1Cyc.size() + e4Cyc.size(), 0);
        checkOutput("t1_busy", {30'd0, bus1.busy, bus4.busy}, 0);
        checkOutput("t1_data", {16'd0, bus1.data, bus4.data}, 0);

        // single frame 0x55
        applyStimulus(1, 8'h55, 1'b1, s);
        repeat (4) holdBit(1, 1'b1);
        checkOutput("t2_valid_cnt", v1Cyc.size(), 1);
        checkOutput("t2_valid_cyc", (v1Cyc.size() > 0) ? v1Cyc[0] : -1, s + 10 + SYNC_LAT);
        checkOutput("t2_data", bus1.data, 8'h55);
        checkOutput("t2_busy", bus1.busy, 1'b0);

        // back-to-back frames, no idle gap
        clearQueues();
        applyStimulus(1, 8'hA5, 1'b1, s);
        applyStimulus(1, 8'h3C, 1'b1, s2);
        repeat (4) holdBit(1, 1'b1);
        checkOutput("t3_valid_cnt", v1Cyc.size(), 2);
        checkOutput("t3_first_cyc", (v1Cyc.size() > 0) ? v1Cyc[0] : -1, s + 10 + SYNC_LAT);
        checkOutput("t3_spacing", (v1Cyc.size() > 1) ? v1Cyc[1] - v1Cyc[0] : -1, 10);
        checkOutput("t3_first_dat", (v1Dat.size() > 0) ? v1Dat[0] : 8'h00, 8'hA5);
        checkOutput("t3_second_dat", (v1Dat.size() > 1) ? v1Dat[1] : 8'h00, 8'h3C);

        // bad stop bit then line held low
        clearQueues();
        applyStimulus(1, 8'hFF, 1'b0, s);
        repeat (5) holdBit(1, 1'b0);
        checkOutput("t4_err_cnt", e1Cyc.size(), 1);
        checkOutput("t4_err_cyc", (e1Cyc.size() > 0) ? e1Cyc[0] : -1, s + 10 + SYNC_LAT);
        checkOutput("t4_no_valid", v1Cyc.size(), 0);
        checkOutput("t4_data_held", bus1.data, 8'h3C);
        checkOutput("t4_busy_break", bus1.busy, 1'b1);
        repeat (4) holdBit(1, 1'b1);
        checkOutput("t4_busy_release", bus1.busy, 1'b0);
        checkOutput("t4_no_new_frame", v1Cyc.size() + e1Cyc.size(), 1);

        // 4 clk/bit: short glitch, then frame 0x81
        holdBit(1, 1'b1);
        setRx(4, 1'b0);
        @(posedge clk);
        #1;
        setRx(4, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("t5_glitch_out", v4Cyc.size() + e4Cyc.size(), 0);
        checkOutput("t5_glitch_busy", bus4.busy, 1'b0);
        applyStimulus(4, 8'h81, 1'b1, s);
        repeat (4) holdBit(4, 1'b1);
        checkOutput("t5_valid_cnt", v4Cyc.size(), 1);
        checkOutput("t5_valid_cyc", (v4Cyc.size() > 0) ? v4Cyc[0] : -1, s + 38 + SYNC_LAT);
        checkOutput("t5_data", bus4.data, 8'h81);
        checkOutput("t5_err_cnt", e4Cyc.size(), 0);

        // reset in the middle of a frame, then a clean frame
        clearQueues();
        holdBit(1, 1'b0);
        for (int i = 0; i < 4; i++) holdBit(1, 1'b1);
        setRx(1, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("t6_abort_out", v1Cyc.size() + e1Cyc.size(), 0);
        checkOutput("t6_abort_data", bus1.data, 8'h00);
        checkOutput("t6_abort_busy", bus1.busy, 1'b0);
        applyStimulus(1, 8'h12, 1'b1, s);
        repeat (4) holdBit(1, 1'b1);
        checkOutput("t6_valid_cnt", v1Cyc.size(), 1);
        checkOutput("t6_valid_cyc", (v1Cyc.size() > 0) ? v1Cyc[0] : -1, s + 10 + SYNC_LAT);
        checkOutput("t6_data", bus1.data, 8'h12);

        checkOutput("valid_and_err_together", bothCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
